// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bus of serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if import serial_sub_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_sub_subbit.sv
// Combinational one-bit full subtractor: x - y - bi.
module subbit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial A - B - Bin, LSB first, through a single subbit cell.
// Signed overflow output is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub import serial_sub_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  serial_sub_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  subbit u_subbit (
    .x  (r_ra[0]),
    .y  (r_rb[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next_state = ST_SHIFT; else w_next_state = ST_IDLE;
      ST_SHIFT: if (w_last)    w_next_state = ST_DONE;  else w_next_state = ST_SHIFT;
      ST_DONE:  if (bus.start) w_next_state = ST_SHIFT; else w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_SHIFT);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Operand shift, borrow chain and result capture; cnt holds at the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_ra   <= bus.a;
      r_rb   <= bus.b;
      r_br   <= bus.bin;
      r_cnt  <= '0;
      r_diff <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (r_state == ST_SHIFT) begin
      r_ra   <= r_ra >> 1;
      r_rb   <= r_rb >> 1;
      r_br   <= w_bo;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      if (w_last) begin
        r_bout <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
        r_ovf  <= (r_ra[0] ^ r_rb[0]) & (w_d ^ r_ra[0]);
`endif
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): vector table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_sub_if #(.WIDTH(W)) sif ();

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return sif.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(a) - int'(b) - int'(bin);
    d  = u[7:0];
    bo = (int'(a) < int'(b) + int'(bin));
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov = (s < -128) || (s > 127);
  endtask

  // One operation; inject >= 0 pulses start with a=0xFF at that SHIFT sample.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input int inject, output logic [7:0] odiff, output logic obout,
                       output logic oovf, output int lat, output int nbusy);
    logic got;
    int   overlap;
    @(negedge clk);
    sif.start = 1'b1; sif.a = ia; sif.b = ib; sif.bin = ibin;
    @(negedge clk);
    sif.start = 1'b0;
    lat = 1; nbusy = 0; got = 1'b0; overlap = 0;
    odiff = 8'h00; obout = 1'b0; oovf = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (sif.busy && sif.done) overlap++;
      if (sif.busy) nbusy++;
      if (sif.done) begin
        got = 1'b1;
        odiff = sif.diff; obout = sif.bout; oovf = get_ovf();
      end else begin
        sif.start = (i == inject);
        if (i == inject) begin
          sif.a = 8'hFF; sif.b = 8'h00; sif.bin = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    sif.start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("busy_done_exclusive", overlap, 32'd0);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic       bo, ov, ebo, eov;
    int         lat, nb, n;
    logic       got2;

    checks = 0; failures = 0;
    sif.start = 1'b0; sif.a = 8'h00; sif.b = 8'h00; sif.bin = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[7] = '{8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, sif.busy}, 32'd0);
    chk("rst_done", {31'd0, sif.done}, 32'd0);
    chk("rst_diff", {24'd0, sif.diff}, 32'd0);
    chk("rst_bout", {31'd0, sif.bout}, 32'd0);
    chk("rst_ovf",  {31'd0, get_ovf()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, -1, d, bo, ov, lat, nb);
      chk($sformatf("vec%0d_diff", i), {24'd0, d}, {24'd0, vecs[i].exp_diff});
      chk($sformatf("vec%0d_bout", i), {31'd0, bo}, {31'd0, vecs[i].exp_bout});
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].exp_ovf});
`endif
      chk($sformatf("vec%0d_latency", i), lat, 32'd9);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 32'd8);
      @(negedge clk);
      chk($sformatf("vec%0d_idle_hold", i), {23'd0, sif.done, sif.diff}, {24'd0, vecs[i].exp_diff});
    end

    // start during SHIFT with different operands must be ignored
    do_op(8'h35, 8'h12, 1'b0, 2, d, bo, ov, lat, nb);
    chk("ignored_start_diff", {24'd0, d}, 32'h23);
    chk("ignored_start_lat", lat, 32'd9);

    // back-to-back: start during the DONE cycle
    do_op(8'h35, 8'h12, 1'b0, -1, d, bo, ov, lat, nb);
    chk("b2b_first_diff", {24'd0, d}, 32'h23);
    sif.start = 1'b1; sif.a = 8'h09; sif.b = 8'h03; sif.bin = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    n = 1; got2 = 1'b0;
    for (int i = 0; i < 40 && !got2; i++) begin
      if (sif.done) got2 = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("b2b_done_seen", {31'd0, got2}, 32'd1);
    chk("b2b_spacing", n, 32'd9);
    chk("b2b_second_diff", {24'd0, sif.diff}, 32'h06);

    // asynchronous reset mid-operation
    @(negedge clk);
    sif.start = 1'b1; sif.a = 8'hFF; sif.b = 8'h00; sif.bin = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, sif.busy}, 32'd0);
    chk("midrst_done", {31'd0, sif.done}, 32'd0);
    chk("midrst_diff", {24'd0, sif.diff}, 32'd0);
    chk("midrst_bout", {31'd0, sif.bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h80, 8'h80, 1'b0, -1, d, bo, ov, lat, nb);
    chk("postrst_diff", {24'd0, d}, 32'h00);
    chk("postrst_bout", {31'd0, bo}, 32'd0);
    chk("postrst_lat", lat, 32'd9);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rbin;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, ed, ebo, eov);
      do_op(ra, rb, rbin, -1, d, bo, ov, lat, nb);
      chk($sformatf("rnd%0d_diff_%h_%h_%0d", i, ra, rb, rbin), {24'd0, d}, {24'd0, ed});
      chk($sformatf("rnd%0d_bout", i), {31'd0, bo}, {31'd0, ebo});
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), {31'd0, ov}, {31'd0, eov});
`endif
      chk($sformatf("rnd%0d_lat", i), lat, 32'd9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
